vga_timing_prog: RTL and testbench

Runtime-programmable VGA/DVI timing generator, successor to the fixed-parameter timing block.
- Produces sync, data-enable, frame and line strobes, plus signed screen coordinates.
- Timing fields and sync polarities are loaded through a valid/ready config port.
- A new config is applied only at a frame boundary, so the display never sees a torn frame.
- Sits in the clk_pixel domain, between the clock generator and the pixel/sprite pipeline.

---
 rtl/vga_timing_prog.sv | 157 +++++++++++++++
 tb/tb_vga_timing_prog.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_prog.sv
// vga_timing_prog: runtime-programmable VGA/DVI timing generator; configs apply only at frame end.
// Define VGA_TIMING_CFG_CHECK_EN to add cfg_err and reject illegal configs on accept.
module vga_timing_prog #(
    parameter int COORD_WIDTH = 16,
    parameter int FIELD_WIDTH = 12,
    parameter int DEF_H_RES   = 640,
    parameter int DEF_H_FP    = 16,
    parameter int DEF_H_SYNC  = 96,
    parameter int DEF_H_BP    = 48,
    parameter int DEF_V_RES   = 480,
    parameter int DEF_V_FP    = 10,
    parameter int DEF_V_SYNC  = 2,
    parameter int DEF_V_BP    = 33,
    parameter int DEF_H_POL   = 0,
    parameter int DEF_V_POL   = 0
) (
    input  logic                          clk_pixel,
    input  logic                          rst_pixel,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [FIELD_WIDTH-1:0]        cfg_h_res,
    input  logic [FIELD_WIDTH-1:0]        cfg_h_fp,
    input  logic [FIELD_WIDTH-1:0]        cfg_h_sync,
    input  logic [FIELD_WIDTH-1:0]        cfg_h_bp,
    input  logic [FIELD_WIDTH-1:0]        cfg_v_res,
    input  logic [FIELD_WIDTH-1:0]        cfg_v_fp,
    input  logic [FIELD_WIDTH-1:0]        cfg_v_sync,
    input  logic [FIELD_WIDTH-1:0]        cfg_v_bp,
    input  logic                          cfg_h_pol,
    input  logic                          cfg_v_pol,
    output logic                          cfg_pending,
`ifdef VGA_TIMING_CFG_CHECK_EN
    output logic                          cfg_err,
`endif
    output logic                          hsync,
    output logic                          vsync,
    output logic                          data_enable,
    output logic                          frame,
    output logic                          line,
    output logic signed [COORD_WIDTH-1:0] screen_x,
    output logic signed [COORD_WIDTH-1:0] screen_y
);
    localparam int CW = COORD_WIDTH;
    localparam int FW = FIELD_WIDTH;

    typedef struct packed {
        logic [FW-1:0] h_res, h_fp, h_sync, h_bp, v_res, v_fp, v_sync, v_bp;
        logic          h_pol, v_pol;
    } cfg_t;

    localparam cfg_t DEF_CFG = {FW'(DEF_H_RES), FW'(DEF_H_FP), FW'(DEF_H_SYNC), FW'(DEF_H_BP),
                                FW'(DEF_V_RES), FW'(DEF_V_FP), FW'(DEF_V_SYNC), FW'(DEF_V_BP),
                                1'(DEF_H_POL), 1'(DEF_V_POL)};

    function automatic logic signed [CW-1:0] zx(input logic [FW-1:0] f);
        return $signed({{(CW-FW){1'b0}}, f});
    endfunction

    function automatic logic signed [CW-1:0] h_start(input cfg_t c);
        return -(zx(c.h_fp) + zx(c.h_sync) + zx(c.h_bp));
    endfunction

    function automatic logic signed [CW-1:0] v_start(input cfg_t c);
        return -(zx(c.v_fp) + zx(c.v_sync) + zx(c.v_bp));
    endfunction

    localparam logic signed [CW-1:0] RST_X = h_start(DEF_CFG);
    localparam logic signed [CW-1:0] RST_Y = v_start(DEF_CFG);

    cfg_t                   r_act, r_shd;
    logic                   r_pending;
    logic signed [CW-1:0]   r_x, r_y;
    cfg_t                   w_cfg_in;
    logic signed [CW-1:0]   w_h_start, w_hs_start, w_hs_end, w_ha_end;
    logic signed [CW-1:0]   w_v_start, w_vs_start, w_vs_end, w_va_end;
    logic                   w_line_end, w_frame_end, w_apply, w_accept, w_in_hs, w_in_vs;

    assign w_cfg_in    = {cfg_h_res, cfg_h_fp, cfg_h_sync, cfg_h_bp,
                          cfg_v_res, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_h_pol, cfg_v_pol};
    assign w_h_start   = h_start(r_act);
    assign w_hs_start  = w_h_start + zx(r_act.h_fp);
    assign w_hs_end    = w_hs_start + zx(r_act.h_sync);
    assign w_ha_end    = zx(r_act.h_res) - CW'(1);
    assign w_v_start   = v_start(r_act);
    assign w_vs_start  = w_v_start + zx(r_act.v_fp);
    assign w_vs_end    = w_vs_start + zx(r_act.v_sync);
    assign w_va_end    = zx(r_act.v_res) - CW'(1);
    assign w_line_end  = r_x == w_ha_end;
    assign w_frame_end = w_line_end && r_y == w_va_end;
    assign w_apply     = w_frame_end && r_pending;
    assign w_in_hs     = r_x >= w_hs_start && r_x < w_hs_end;
    assign w_in_vs     = r_y >= w_vs_start && r_y < w_vs_end;
    assign cfg_ready   = ~r_pending;
    assign cfg_pending = r_pending;

`ifdef VGA_TIMING_CFG_CHECK_EN
    localparam int MAX_SUM = (1 << (CW - 1)) - 1;
    logic [31:0] w_h_sum, w_v_sum;
    logic        w_bad;
    assign w_h_sum  = 32'(cfg_h_res) + 32'(cfg_h_fp) + 32'(cfg_h_sync) + 32'(cfg_h_bp);
    assign w_v_sum  = 32'(cfg_v_res) + 32'(cfg_v_fp) + 32'(cfg_v_sync) + 32'(cfg_v_bp);
    assign w_bad    = ~|cfg_h_res || ~|cfg_v_res || ~|cfg_h_sync || ~|cfg_v_sync ||
                      w_h_sum > MAX_SUM || w_v_sum > MAX_SUM;
    assign w_accept = cfg_valid && !r_pending && !w_bad;
    always_ff @(posedge clk_pixel or posedge rst_pixel) begin
        if (rst_pixel) cfg_err <= 1'b0;
        else           cfg_err <= cfg_valid && !r_pending && w_bad;
    end
`else
    assign w_accept = cfg_valid && !r_pending;
`endif

    // Apply and accept are exclusive: apply needs pending set, accept needs it clear.
    always_ff @(posedge clk_pixel or posedge rst_pixel) begin
        if (rst_pixel) begin
            r_act     <= DEF_CFG;
            r_shd     <= DEF_CFG;
            r_pending <= 1'b0;
            r_x       <= RST_X;
            r_y       <= RST_Y;
        end else begin
            if (w_apply) begin
                r_act     <= r_shd;
                r_pending <= 1'b0;
            end else if (w_accept) begin
                r_shd     <= w_cfg_in;
                r_pending <= 1'b1;
            end
            if (w_line_end) begin
                r_x <= w_apply ? h_start(r_shd) : w_h_start;
                r_y <= w_frame_end ? (w_apply ? v_start(r_shd) : w_v_start) : r_y + CW'(1);
            end else begin
                r_x <= r_x + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge rst_pixel) begin
        if (rst_pixel) begin
            hsync       <= ~DEF_CFG.h_pol;
            vsync       <= ~DEF_CFG.v_pol;
            data_enable <= 1'b0;
            frame       <= 1'b0;
            line        <= 1'b0;
            screen_x    <= '0;
            screen_y    <= '0;
        end else begin
            hsync       <= r_act.h_pol ? w_in_hs : ~w_in_hs;
            vsync       <= r_act.v_pol ? w_in_vs : ~w_in_vs;
            data_enable <= !r_x[CW-1] && !r_y[CW-1];
            frame       <= r_x == w_h_start && r_y == w_v_start;
            line        <= !r_y[CW-1] && r_x == w_h_start;
            screen_x    <= r_x;
            screen_y    <= r_y;
        end
    end
endmodule

// File: tb/tb_vga_timing_prog.sv
// tb_vga_timing_prog: bench for vga_timing_prog; a frame-index model checks a small-default
// instance every cycle, and a full-default instance is pinned with literal 800/525 timing values.
module tb_vga_timing_prog;
    typedef struct packed {
        logic [11:0] hr, hf, hs, hb, vr, vf, vs, vb;
        logic        hp, vp;
    } cfg_t;

    localparam cfg_t DEF = {12'd16, 12'd2, 12'd3, 12'd2, 12'd6, 12'd1, 12'd2, 12'd2, 1'b0, 1'b0};
    localparam cfg_t C1  = {12'd8, 12'd1, 12'd2, 12'd1, 12'd4, 12'd1, 12'd1, 12'd1, 1'b1, 1'b1};
    localparam cfg_t C3  = {12'd6, 12'd1, 12'd1, 12'd1, 12'd3, 12'd1, 12'd1, 12'd1, 1'b0, 1'b1};
    localparam cfg_t C4  = {12'd10, 12'd1, 12'd1, 12'd1, 12'd2, 12'd1, 12'd1, 12'd1, 1'b1, 1'b0};
    localparam cfg_t C5  = {12'd5, 12'd1, 12'd3, 12'd1, 12'd3, 12'd1, 12'd1, 12'd1, 1'b1, 1'b1};

    logic clk_pixel = 1'b0;
    logic rst_pixel = 1'b1;
    logic rst_d     = 1'b1;
    logic cfg_valid = 1'b0;
    cfg_t cin       = '0;
    logic ready, pending, hsync, vsync, de, frame, line;
    logic signed [15:0] sx, sy;
    logic d_ready, d_pending, d_hs, d_vs, d_de, d_frame, d_line;
    logic signed [15:0] d_sx, d_sy;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    always #5 clk_pixel = ~clk_pixel;

    vga_timing_prog #(
        .DEF_H_RES(16), .DEF_H_FP(2), .DEF_H_SYNC(3), .DEF_H_BP(2),
        .DEF_V_RES(6), .DEF_V_FP(1), .DEF_V_SYNC(2), .DEF_V_BP(2)
    ) u_dut (
        .clk_pixel(clk_pixel), .rst_pixel(rst_pixel), .cfg_valid(cfg_valid), .cfg_ready(ready),
        .cfg_h_res(cin.hr), .cfg_h_fp(cin.hf), .cfg_h_sync(cin.hs), .cfg_h_bp(cin.hb),
        .cfg_v_res(cin.vr), .cfg_v_fp(cin.vf), .cfg_v_sync(cin.vs), .cfg_v_bp(cin.vb),
        .cfg_h_pol(cin.hp), .cfg_v_pol(cin.vp), .cfg_pending(pending),
        .hsync(hsync), .vsync(vsync), .data_enable(de), .frame(frame), .line(line),
        .screen_x(sx), .screen_y(sy)
    );

    vga_timing_prog u_def (
        .clk_pixel(clk_pixel), .rst_pixel(rst_d), .cfg_valid(1'b0), .cfg_ready(d_ready),
        .cfg_h_res(cin.hr), .cfg_h_fp(cin.hf), .cfg_h_sync(cin.hs), .cfg_h_bp(cin.hb),
        .cfg_v_res(cin.vr), .cfg_v_fp(cin.vf), .cfg_v_sync(cin.vs), .cfg_v_bp(cin.vb),
        .cfg_h_pol(cin.hp), .cfg_v_pol(cin.vp), .cfg_pending(d_pending),
        .hsync(d_hs), .vsync(d_vs), .data_enable(d_de), .frame(d_frame), .line(d_line),
        .screen_x(d_sx), .screen_y(d_sy)
    );

    function automatic int hst(input cfg_t c);
        return -(int'(c.hf) + int'(c.hs) + int'(c.hb));
    endfunction
    function automatic int vst(input cfg_t c);
        return -(int'(c.vf) + int'(c.vs) + int'(c.vb));
    endfunction
    function automatic int htot(input cfg_t c);
        return int'(c.hr) - hst(c);
    endfunction
    function automatic int vtot(input cfg_t c);
        return int'(c.vr) - vst(c);
    endfunction
    function automatic int px(input cfg_t c, input int k);
        return hst(c) + k % htot(c);
    endfunction
    function automatic int py(input cfg_t c, input int k);
        return vst(c) + k / htot(c);
    endfunction
    function automatic bit in_hs(input cfg_t c, input int k);
        return px(c, k) >= hst(c) + int'(c.hf) && px(c, k) < hst(c) + int'(c.hf) + int'(c.hs);
    endfunction
    function automatic bit in_vs(input cfg_t c, input int k);
        return py(c, k) >= vst(c) + int'(c.vf) && py(c, k) < vst(c) + int'(c.vf) + int'(c.vs);
    endfunction

    // Model state: n is the cycle index within the current frame of the active timing.
    cfg_t act = DEF;
    cfg_t shd = DEF;
    bit   pend = 1'b0;
    int   n = 0;
    logic e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_fr = 1'b0, e_ln = 1'b0;
    int   e_sx = 0, e_sy = 0;

    always @(posedge clk_pixel or posedge rst_pixel) begin
        if (rst_pixel) begin
            act  <= DEF;
            shd  <= DEF;
            pend <= 1'b0;
            n    <= 0;
            e_hs <= !DEF.hp;
            e_vs <= !DEF.vp;
            e_de <= 1'b0;
            e_fr <= 1'b0;
            e_ln <= 1'b0;
            e_sx <= 0;
            e_sy <= 0;
        end else begin
            e_sx <= px(act, n);
            e_sy <= py(act, n);
            e_de <= px(act, n) >= 0 && py(act, n) >= 0;
            e_fr <= n == 0;
            e_ln <= py(act, n) >= 0 && n % htot(act) == 0;
            e_hs <= act.hp ? in_hs(act, n) : !in_hs(act, n);
            e_vs <= act.vp ? in_vs(act, n) : !in_vs(act, n);
            if (n == htot(act) * vtot(act) - 1) begin
                n <= 0;
                if (pend) begin
                    act  <= shd;
                    pend <= 1'b0;
                end
            end else begin
                n <= n + 1;
            end
            if (cfg_valid && !pend) begin
                shd  <= cin;
                pend <= 1'b1;
            end
        end
    end

    always @(negedge clk_pixel) begin
        if (chk_on) begin
            tests++;
            if ({hsync, vsync, de, frame, line, sx, sy, ready, pending} !==
                {e_hs, e_vs, e_de, e_fr, e_ln, 16'(e_sx), 16'(e_sy), !pend, pend}) begin
                fails++;
                $display("FAIL model t=%0t: dut hs=%b vs=%b de=%b fr=%b ln=%b x=%0d y=%0d rdy=%b pnd=%b; want hs=%b vs=%b de=%b fr=%b ln=%b x=%0d y=%0d rdy=%b pnd=%b",
                         $time, hsync, vsync, de, frame, line, sx, sy, ready, pending,
                         e_hs, e_vs, e_de, e_fr, e_ln, e_sx, e_sy, !pend, pend);
            end
        end
    end

    task automatic chk(input string nm, input int a, input int e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, a, e);
        end
    endtask

    task automatic span(input bit use_line, output int c, output int hi);
        c = 0;
        hi = 0;
        do begin
            @(negedge clk_pixel);
            c++;
            if (hsync) hi++;
        end while (!(use_line ? line : frame) && c < 2000);
    endtask

    initial begin
        int c, hi, den, hlo;
        repeat (3) @(negedge clk_pixel);
        chk_on = 1'b1;
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_de", de, 0);
        chk("rst_frame", frame, 0);
        chk("rst_x", sx, 0);
        chk("rst_ready", ready, 1);
        chk("rst_pending", pending, 0);
        chk("def_rst_x", d_sx, 0);
        chk("def_rst_hsync", d_hs, 1);
        rst_pixel = 1'b0;
        rst_d = 1'b0;
        @(negedge clk_pixel);
        chk("first_x", sx, -7);
        chk("first_y", sy, -5);
        chk("first_frame", frame, 1);
        chk("def_first_x", d_sx, -160);
        chk("def_first_y", d_sy, -45);
        chk("def_first_hsync", d_hs, 1);
        c = 0;
        do begin @(negedge clk_pixel); c++; end while (!d_line && c < 40000);
        chk("def_line0_wait", c, 36000);
        chk("def_line0_y", d_sy, 0);
        c = 0; den = 0; hlo = 0;
        do begin
            @(negedge clk_pixel);
            c++;
            if (d_de) den++;
            if (!d_hs) hlo++;
            if (d_sx == -145) chk("def_hsync_before", d_hs, 1);
            if (d_sx == -144) chk("def_hsync_first_low", d_hs, 0);
        end while (!d_line && c < 2000);
        chk("def_line_period", c, 800);
        chk("def_de_per_line", den, 640);
        chk("def_hsync_low", hlo, 96);
        repeat (200) @(negedge clk_pixel);
        @(posedge clk_pixel);
        #2 rst_d = 1'b1;
        #1;
        chk("def_async_rst_x", d_sx, 0);
        chk("def_async_rst_de", d_de, 0);
        chk("def_async_rst_hsync", d_hs, 1);
        @(negedge clk_pixel);
        rst_d = 1'b0;
        @(negedge clk_pixel);
        chk("def_resume_x", d_sx, -160);
        chk("def_resume_y", d_sy, -45);

        c = 0;
        do begin @(negedge clk_pixel); c++; end while (n != 50 && c < 1000);
        cin = C1;
        cfg_valid = 1'b1;
        @(negedge clk_pixel);
        cfg_valid = 1'b0;
        chk("c1_ready_drop", ready, 0);
        span(1'b0, c, hi);
        chk("c1_ready_back", ready, 1);
        span(1'b0, c, hi);
        chk("c1_frame_len", c, 84);
        span(1'b1, c, hi);
        span(1'b1, c, hi);
        chk("c1_line_len", c, 12);
        chk("c1_hsync_high", hi, 2);

        c = 0;
        do begin @(negedge clk_pixel); c++; end while (n != 83 && c < 1000);
        cin = C3;
        cfg_valid = 1'b1;
        @(negedge clk_pixel);
        cfg_valid = 1'b0;
        chk("c3_accept_at_end", pending, 1);
        span(1'b0, c, hi);
        chk("c3_sync", c, 1);
        span(1'b0, c, hi);
        chk("c3_old_frame", c, 84);
        span(1'b0, c, hi);
        chk("c3_new_frame", c, 54);

        repeat (3) @(negedge clk_pixel);
        cin = C4;
        cfg_valid = 1'b1;
        @(negedge clk_pixel);
        cin = C5;
        @(negedge clk_pixel);
        cfg_valid = 1'b0;
        chk("second_valid_pending", pending, 1);
        chk("second_valid_ready", ready, 0);
        span(1'b0, c, hi);
        span(1'b0, c, hi);
        chk("c4_frame_not_c5", c, 65);
        span(1'b1, c, hi);
        span(1'b1, c, hi);
        chk("c4_line_len", c, 13);

        repeat (5) @(negedge clk_pixel);
        cin = C5;
        cfg_valid = 1'b1;
        @(negedge clk_pixel);
        cfg_valid = 1'b0;
        chk("c5_pending", pending, 1);
        @(posedge clk_pixel);
        #2 rst_pixel = 1'b1;
        #1;
        chk("async_rst_pending", pending, 0);
        chk("async_rst_ready", ready, 1);
        chk("async_rst_x", sx, 0);
        chk("async_rst_hsync", hsync, 1);
        @(negedge clk_pixel);
        rst_pixel = 1'b0;
        @(negedge clk_pixel);
        chk("resume_x", sx, -7);
        chk("resume_y", sy, -5);
        span(1'b0, c, hi);
        chk("resume_default_frame", c, 253);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
